// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// opcodes, funct codes, FSM states, ALU operations and datapath selects.
package mips_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // FSM state encoding (also visible on the debug state port)
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  // Next-PC source
  localparam logic [1:0] SELPC_PC4    = 2'b00;
  localparam logic [1:0] SELPC_BRANCH = 2'b01;
  localparam logic [1:0] SELPC_JUMP   = 2'b10;
  localparam logic [1:0] SELPC_RS     = 2'b11;

  // Register-file write data source
  localparam logic [1:0] DIN_PC   = 2'b00;
  localparam logic [1:0] DIN_DMEM = 2'b01;
  localparam logic [1:0] DIN_ALU  = 2'b10;

  // Register-file write address source
  localparam logic [1:0] WADR_RT  = 2'b00;
  localparam logic [1:0] WADR_R31 = 2'b01;
  localparam logic [1:0] WADR_RD  = 2'b10;

  // True for the jr instruction (R-type with funct jr)
  function automatic logic is_jr(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn == FN_JR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// Combinational instruction decode: ALU operation, operand-B select and
// immediate extension, plus a flag for unsupported opcode/funct values.
module alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       sel_b,
  output logic       sgn,
  output logic       illegal
);

  // Map opcode/funct to ALU controls; anything unsupported raises illegal
  always_comb begin
    alu_op  = ALU_ADD;
    sel_b   = 1'b0;
    sgn     = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_SLT:  alu_op = ALU_SLT;
          FN_JR:   alu_op = ALU_ADD;
          default: illegal = 1'b1;
        endcase
      end
      OP_J, OP_JAL: alu_op = ALU_ADD;
      OP_BNE:       alu_op = ALU_SUB;
      OP_ADDI: begin
        sel_b = 1'b1;
        sgn   = 1'b1;
      end
      OP_XORI: begin
        alu_op = ALU_XOR;
        sel_b  = 1'b1;
      end
      OP_LW, OP_SW: begin
        sel_b = 1'b1;
        sgn   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, owns the shared memory port and counts
// retired instructions. Outputs are combinational from state and IR.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_adr,
  output logic        ir_wen,
  output logic        pc_wen,
  output logic        rf_wen,
  output logic [1:0]  sel_pc,
  output logic [1:0]  rf_seldin,
  output logic [1:0]  rf_selwadr,
  output logic        sel_b,
  output logic        sgn,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);

  logic [2:0]  state_q, state_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic [2:0]  dec_alu_op;
  logic        dec_sel_b, dec_sgn, dec_illegal;
  logic        retire;

  alu_decode u_alu_decode (
    .opcode  (opcode),
    .funct   (funct),
    .alu_op  (dec_alu_op),
    .sel_b   (dec_sel_b),
    .sgn     (dec_sgn),
    .illegal (dec_illegal)
  );

  // Next-state and strobe/select generation; everything is forced low in reset
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_sel_adr = 1'b0;
    ir_wen      = 1'b0;
    pc_wen      = 1'b0;
    rf_wen      = 1'b0;
    sel_pc      = SELPC_PC4;
    rf_seldin   = DIN_PC;
    rf_selwadr  = WADR_RT;
    sel_b       = 1'b0;
    sgn         = 1'b0;
    alu_op      = ALU_ADD;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_wen  = 1'b1;
            pc_wen  = 1'b1;
            state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            state_d = S_HALT;
          end else if (opcode == OP_J || opcode == OP_JAL) begin
            pc_wen  = 1'b1;
            sel_pc  = SELPC_JUMP;
            state_d = S_FETCH;
            if (opcode == OP_JAL) begin
              rf_wen     = 1'b1;
              rf_selwadr = WADR_R31;
              rf_seldin  = DIN_PC;
            end else begin
              rf_wen = 1'b0;
            end
          end else if (is_jr(opcode, funct)) begin
            pc_wen  = 1'b1;
            sel_pc  = SELPC_RS;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_op = dec_alu_op;
          sel_b  = dec_sel_b;
          sgn    = dec_sgn;
          case (opcode)
            OP_RTYPE, OP_ADDI, OP_XORI: state_d = S_WB;
            OP_LW, OP_SW:               state_d = S_MEM;
            OP_BNE: begin
              pc_wen  = ~alu_zero;
              sel_pc  = SELPC_BRANCH;
              state_d = S_FETCH;
            end
            default: state_d = S_HALT;
          endcase
        end
        S_MEM: begin
          alu_op      = dec_alu_op;
          sel_b       = dec_sel_b;
          sgn         = dec_sgn;
          mem_req     = 1'b1;
          mem_sel_adr = 1'b1;
          mem_we      = (opcode == OP_SW);
          if (mem_ready) begin
            state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
          end else begin
            state_d = S_MEM;
          end
        end
        S_WB: begin
          state_d = S_FETCH;
          case (opcode)
            OP_RTYPE: begin
              rf_wen     = 1'b1;
              rf_selwadr = WADR_RD;
              rf_seldin  = DIN_ALU;
            end
            OP_ADDI, OP_XORI: begin
              rf_wen     = 1'b1;
              rf_selwadr = WADR_RT;
              rf_seldin  = DIN_ALU;
            end
            OP_LW: begin
              rf_wen     = 1'b1;
              rf_selwadr = WADR_RT;
              rf_seldin  = DIN_DMEM;
            end
            default: rf_wen = 1'b0;
          endcase
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_HALT;
      endcase
    end else begin
      state_d = S_FETCH;
    end
  end

  // An instruction retires whenever a working state hands back to FETCH
  always_comb begin
    retire = (state_d == S_FETCH) &&
             ((state_q == S_DECODE) || (state_q == S_EXEC) ||
              (state_q == S_MEM) || (state_q == S_WB));
    if (retire) begin
      instr_count_d = instr_count_q + 32'd1;
    end else begin
      instr_count_d = instr_count_q;
    end
  end

  // State and retired-instruction counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each scenario queues per-cycle
// stimulus with the expected outputs, then drains the queue cycle by cycle.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h00;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_sel_adr, ir_wen, pc_wen, rf_wen;
  logic [1:0]  sel_pc, rf_seldin, rf_selwadr;
  logic        sel_b, sgn, halted;
  logic [2:0]  alu_op, state;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_sel_adr(mem_sel_adr), .ir_wen(ir_wen),
    .pc_wen(pc_wen), .rf_wen(rf_wen), .sel_pc(sel_pc), .rf_seldin(rf_seldin),
    .rf_selwadr(rf_selwadr), .sel_b(sel_b), .sgn(sgn), .alu_op(alu_op),
    .state(state), .halted(halted), .instr_count(instr_count)
  );

  typedef struct packed {
    logic [2:0]  state;
    logic        mem_req, mem_we, mem_sel_adr, ir_wen, pc_wen, rf_wen;
    logic [1:0]  sel_pc, rf_seldin, rf_selwadr;
    logic        sel_b, sgn;
    logic [2:0]  alu_op;
    logic        halted;
    logic [31:0] count;
  } obs_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       mr;
    logic       az;
    obs_t       exp;
  } ent_t;

  ent_t        sb[$];
  ent_t        ent;
  obs_t        obs;
  obs_t        e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc;
  logic [31:0] exp_cnt = 32'd0;

  // Gather the DUT outputs into one comparable word
  always_comb begin
    obs             = '0;
    obs.state       = state;
    obs.mem_req     = mem_req;
    obs.mem_we      = mem_we;
    obs.mem_sel_adr = mem_sel_adr;
    obs.ir_wen      = ir_wen;
    obs.pc_wen      = pc_wen;
    obs.rf_wen      = rf_wen;
    obs.sel_pc      = sel_pc;
    obs.rf_seldin   = rf_seldin;
    obs.rf_selwadr  = rf_selwadr;
    obs.sel_b       = sel_b;
    obs.sgn         = sgn;
    obs.alu_op      = alu_op;
    obs.halted      = halted;
    obs.count       = instr_count;
  end

  function automatic obs_t base(input logic [2:0] st);
    obs_t o;
    o       = '0;
    o.state = st;
    o.count = exp_cnt;
    return o;
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic az, input obs_t x);
    sb.push_back('{op, fn, mr, az, x});
  endtask

  // FETCH cycle where memory answers at once
  task automatic push_fetch(input logic [5:0] op, input logic [5:0] fn);
    obs_t x;
    x = base(S_FETCH);
    x.mem_req = 1'b1; x.ir_wen = 1'b1; x.pc_wen = 1'b1;
    push(op, fn, 1'b1, 1'b0, x);
  endtask

  // FETCH cycle where memory is not ready
  task automatic push_stall(input logic [5:0] op, input logic [5:0] fn);
    obs_t x;
    x = base(S_FETCH);
    x.mem_req = 1'b1;
    push(op, fn, 1'b0, 1'b0, x);
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    opcode = OP_ADDI;
    exp_cnt = 32'd0;
    for (int i = 0; i < 3; i++) push(OP_ADDI, 6'h00, 1'b1, 1'b0, base(S_FETCH));
    cyc = 0;
    while (sb.size() != 0) begin
      ent = sb.pop_front();
      @(negedge clk);
      opcode = ent.op; funct = ent.fn; mem_ready = ent.mr; alu_zero = ent.az;
      #1;
      n_checks++;
      if (obs !== ent.exp) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d got=%h exp=%h", cyc, obs, ent.exp);
      end
      cyc++;
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    e = base(S_FETCH);
    e.mem_req = 1'b1;
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_add();
    push_fetch(OP_RTYPE, FN_ADD);
    push(OP_RTYPE, FN_ADD, 1'b1, 1'b0, base(S_DECODE));
    e = base(S_EXEC); e.alu_op = ALU_ADD;
    push(OP_RTYPE, FN_ADD, 1'b1, 1'b0, e);
    e = base(S_WB); e.rf_wen = 1'b1; e.rf_selwadr = WADR_RD; e.rf_seldin = DIN_ALU;
    push(OP_RTYPE, FN_ADD, 1'b1, 1'b0, e);
    exp_cnt = exp_cnt + 32'd1;
    push_stall(OP_RTYPE, FN_ADD);
    cyc = 0;
    while (sb.size() != 0) begin
      ent = sb.pop_front();
      @(negedge clk);
      opcode = ent.op; funct = ent.fn; mem_ready = ent.mr; alu_zero = ent.az;
      #1;
      n_checks++;
      if (obs !== ent.exp) begin
        n_fail++;
        $display("FAIL add cyc%0d got=%h exp=%h", cyc, obs, ent.exp);
      end
      cyc++;
    end
  endtask

  // sub, slt, addi, xori issued back to back with no idle FETCH between them
  task automatic test_back_to_back();
    logic [5:0] t_op [4];
    logic [5:0] t_fn [4];
    logic [2:0] t_alu [4];
    logic [1:0] t_wadr [4];
    logic       t_selb [4];
    logic       t_sgn [4];
    t_op = '{OP_RTYPE, OP_RTYPE, OP_ADDI, OP_XORI};
    t_fn = '{FN_SUB, FN_SLT, 6'h15, 6'h3F};
    t_alu = '{ALU_SUB, ALU_SLT, ALU_ADD, ALU_XOR};
    t_wadr = '{WADR_RD, WADR_RD, WADR_RT, WADR_RT};
    t_selb = '{1'b0, 1'b0, 1'b1, 1'b1};
    t_sgn = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      push_fetch(t_op[k], t_fn[k]);
      push(t_op[k], t_fn[k], 1'b1, 1'b0, base(S_DECODE));
      e = base(S_EXEC); e.alu_op = t_alu[k]; e.sel_b = t_selb[k]; e.sgn = t_sgn[k];
      push(t_op[k], t_fn[k], 1'b1, 1'b0, e);
      e = base(S_WB); e.rf_wen = 1'b1; e.rf_selwadr = t_wadr[k]; e.rf_seldin = DIN_ALU;
      push(t_op[k], t_fn[k], 1'b1, 1'b0, e);
      exp_cnt = exp_cnt + 32'd1;
    end
    push_stall(OP_XORI, 6'h00);
    cyc = 0;
    while (sb.size() != 0) begin
      ent = sb.pop_front();
      @(negedge clk);
      opcode = ent.op; funct = ent.fn; mem_ready = ent.mr; alu_zero = ent.az;
      #1;
      n_checks++;
      if (obs !== ent.exp) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d got=%h exp=%h", cyc, obs, ent.exp);
      end
      cyc++;
    end
  endtask

  task automatic test_lw_sw();
    obs_t m;
    // lw: two memory wait cycles in MEM
    push_fetch(OP_LW, 6'h00);
    push(OP_LW, 6'h00, 1'b1, 1'b0, base(S_DECODE));
    e = base(S_EXEC); e.alu_op = ALU_ADD; e.sel_b = 1'b1; e.sgn = 1'b1;
    push(OP_LW, 6'h00, 1'b1, 1'b0, e);
    m = base(S_MEM); m.mem_req = 1'b1; m.mem_sel_adr = 1'b1; m.sel_b = 1'b1; m.sgn = 1'b1;
    push(OP_LW, 6'h00, 1'b0, 1'b0, m);
    push(OP_LW, 6'h00, 1'b0, 1'b0, m);
    push(OP_LW, 6'h00, 1'b1, 1'b0, m);
    e = base(S_WB); e.rf_wen = 1'b1; e.rf_selwadr = WADR_RT; e.rf_seldin = DIN_DMEM;
    push(OP_LW, 6'h00, 1'b1, 1'b0, e);
    exp_cnt = exp_cnt + 32'd1;
    // sw: one wait cycle on the instruction fetch
    push_stall(OP_SW, 6'h00);
    push_fetch(OP_SW, 6'h00);
    push(OP_SW, 6'h00, 1'b1, 1'b0, base(S_DECODE));
    e = base(S_EXEC); e.alu_op = ALU_ADD; e.sel_b = 1'b1; e.sgn = 1'b1;
    push(OP_SW, 6'h00, 1'b1, 1'b0, e);
    m = base(S_MEM); m.mem_req = 1'b1; m.mem_sel_adr = 1'b1; m.mem_we = 1'b1;
    m.sel_b = 1'b1; m.sgn = 1'b1;
    push(OP_SW, 6'h00, 1'b1, 1'b0, m);
    exp_cnt = exp_cnt + 32'd1;
    push_stall(OP_SW, 6'h00);
    cyc = 0;
    while (sb.size() != 0) begin
      ent = sb.pop_front();
      @(negedge clk);
      opcode = ent.op; funct = ent.fn; mem_ready = ent.mr; alu_zero = ent.az;
      #1;
      n_checks++;
      if (obs !== ent.exp) begin
        n_fail++;
        $display("FAIL lw_sw cyc%0d got=%h exp=%h", cyc, obs, ent.exp);
      end
      cyc++;
    end
  endtask

  task automatic test_branch();
    for (int z = 0; z < 2; z++) begin
      push_fetch(OP_BNE, 6'h00);
      push(OP_BNE, 6'h00, 1'b1, 1'(z), base(S_DECODE));
      e = base(S_EXEC); e.alu_op = ALU_SUB; e.sel_pc = SELPC_BRANCH;
      e.pc_wen = (z == 0) ? 1'b1 : 1'b0;
      push(OP_BNE, 6'h00, 1'b1, 1'(z), e);
      exp_cnt = exp_cnt + 32'd1;
    end
    push_stall(OP_BNE, 6'h00);
    cyc = 0;
    while (sb.size() != 0) begin
      ent = sb.pop_front();
      @(negedge clk);
      opcode = ent.op; funct = ent.fn; mem_ready = ent.mr; alu_zero = ent.az;
      #1;
      n_checks++;
      if (obs !== ent.exp) begin
        n_fail++;
        $display("FAIL bne cyc%0d got=%h exp=%h", cyc, obs, ent.exp);
      end
      cyc++;
    end
  endtask

  task automatic test_jumps();
    push_fetch(OP_J, 6'h11);
    e = base(S_DECODE); e.pc_wen = 1'b1; e.sel_pc = SELPC_JUMP;
    push(OP_J, 6'h11, 1'b1, 1'b0, e);
    exp_cnt = exp_cnt + 32'd1;
    push_fetch(OP_JAL, 6'h00);
    e = base(S_DECODE); e.pc_wen = 1'b1; e.sel_pc = SELPC_JUMP; e.rf_wen = 1'b1;
    e.rf_selwadr = WADR_R31; e.rf_seldin = DIN_PC;
    push(OP_JAL, 6'h00, 1'b1, 1'b0, e);
    exp_cnt = exp_cnt + 32'd1;
    push_fetch(OP_RTYPE, FN_JR);
    e = base(S_DECODE); e.pc_wen = 1'b1; e.sel_pc = SELPC_RS;
    push(OP_RTYPE, FN_JR, 1'b1, 1'b0, e);
    exp_cnt = exp_cnt + 32'd1;
    push_stall(OP_RTYPE, FN_JR);
    cyc = 0;
    while (sb.size() != 0) begin
      ent = sb.pop_front();
      @(negedge clk);
      opcode = ent.op; funct = ent.fn; mem_ready = ent.mr; alu_zero = ent.az;
      #1;
      n_checks++;
      if (obs !== ent.exp) begin
        n_fail++;
        $display("FAIL jumps cyc%0d got=%h exp=%h", cyc, obs, ent.exp);
      end
      cyc++;
    end
  endtask

  // Reset while a load is waiting in MEM: request must drop at once
  task automatic test_reset_abort();
    obs_t m;
    push_fetch(OP_LW, 6'h00);
    push(OP_LW, 6'h00, 1'b1, 1'b0, base(S_DECODE));
    e = base(S_EXEC); e.sel_b = 1'b1; e.sgn = 1'b1;
    push(OP_LW, 6'h00, 1'b1, 1'b0, e);
    m = base(S_MEM); m.mem_req = 1'b1; m.mem_sel_adr = 1'b1; m.sel_b = 1'b1; m.sgn = 1'b1;
    push(OP_LW, 6'h00, 1'b0, 1'b0, m);
    cyc = 0;
    while (sb.size() != 0) begin
      ent = sb.pop_front();
      @(negedge clk);
      opcode = ent.op; funct = ent.fn; mem_ready = ent.mr; alu_zero = ent.az;
      #1;
      n_checks++;
      if (obs !== ent.exp) begin
        n_fail++;
        $display("FAIL abort_pre cyc%0d got=%h exp=%h", cyc, obs, ent.exp);
      end
      cyc++;
    end
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    exp_cnt = 32'd0;
    e = base(S_FETCH);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL abort_in_reset got=%h exp=%h", obs, e);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    e = base(S_FETCH); e.mem_req = 1'b1;
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL abort_release got=%h exp=%h", obs, e);
    end
  endtask

  // Illegal opcode and illegal funct both park the FSM in HALT until reset
  task automatic test_halt();
    logic [5:0] h_op [2];
    logic [5:0] h_fn [2];
    h_op = '{6'h3F, OP_RTYPE};
    h_fn = '{6'h00, 6'h21};
    for (int k = 0; k < 2; k++) begin
      push_fetch(h_op[k], h_fn[k]);
      push(h_op[k], h_fn[k], 1'b1, 1'b0, base(S_DECODE));
      e = base(S_HALT); e.halted = 1'b1;
      for (int n = 0; n < 4; n++) push(h_op[k], h_fn[k], 1'b1, 1'(n), e);
      cyc = 0;
      while (sb.size() != 0) begin
        ent = sb.pop_front();
        @(negedge clk);
        opcode = ent.op; funct = ent.fn; mem_ready = ent.mr; alu_zero = ent.az;
        #1;
        n_checks++;
        if (obs !== ent.exp) begin
          n_fail++;
          $display("FAIL halt%0d cyc%0d got=%h exp=%h", k, cyc, obs, ent.exp);
        end
        cyc++;
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      exp_cnt = 32'd0;
      e = base(S_FETCH);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL halt_reset%0d got=%h exp=%h", k, obs, e);
      end
      @(negedge clk);
      reset = 1'b0;
      mem_ready = 1'b0;
      #1;
      e = base(S_FETCH); e.mem_req = 1'b1;
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL halt_release%0d got=%h exp=%h", k, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_lw_sw();
    test_branch();
    test_jumps();
    test_reset_abort();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the MIPS-subset datapath: it replaces the single-cycle combinational controller and steps each instruction through FETCH, DECODE, EXEC, MEM and WB states. It owns the single shared memory port, with instruction fetch and data access arbitrated by state. It drives PC, IR, register-file and memory enables, and datapath mux selects. It sits between the instruction register and the datapath muxes, register file, ALU and memory.

## Interface
- No parameters. Opcode, funct, state and select encodings come from the shared package.
- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; one clock domain
- opcode  in  6  IR[31:26]; stable outside FETCH
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- mem_sel_adr  out  1  0 = PC, 1 = ALU result
- ir_wen, pc_wen, rf_wen  out  1 each  register write enables
- sel_pc  out  2  00 pc+4, 01 branch target, 10 jump {pc[31:28],jadr,00}, 11 rs (jr)
- rf_seldin  out  2  00 pc (already pc+4), 01 dm_dout, 10 alu_res
- rf_selwadr  out  2  00 rt, 01 r31, 10 rd
- sel_b  out  1  1 = extended immediate
- sgn  out  1  1 = sign-extend
- alu_op  out  3  ADD 000, SUB 001, XOR 010, SLT 011
- state  out  3  current state, for debug
- halted  out  1  illegal instruction seen
- instr_count  out  32  retired instructions

## Operation
- Supported instructions: R-type (opcode 0x00) add 0x20, sub 0x22, slt 0x2A, jr 0x08; j 0x02; jal 0x03; bne 0x05; addi 0x08; xori 0x0E; lw 0x23; sw 0x2B.
- FETCH: mem_req=1, mem_sel_adr=0. On mem_ready: ir_wen=1, pc_wen=1, sel_pc=00, then go to DECODE. Without mem_ready, stay in FETCH.
- DECODE:
  - j: pc_wen, sel_pc=10, then FETCH.
  - jal: the same, plus rf_wen, rf_selwadr=01, rf_seldin=00.
  - jr: pc_wen, sel_pc=11, then FETCH.
  - Other legal instructions: go to EXEC.
  - Illegal opcode or funct: go to HALT.
- EXEC:
  - R-type: alu_op from funct, sel_b=0, then WB.
  - addi: ADD, sel_b=1, sgn=1, then WB.
  - xori: XOR, sel_b=1, sgn=0, then WB.
  - lw/sw: ADD, sel_b=1, sgn=1, then MEM.
  - bne: SUB, sel_b=0; pc_wen=~alu_zero, sel_pc=01; then FETCH.
- MEM: mem_req=1, mem_sel_adr=1, mem_we=(sw), ALU inputs held as in EXEC. On mem_ready: lw goes to WB, sw goes to FETCH. Otherwise stay in MEM.
- WB: rf_wen=1, then FETCH.
  - R-type: rf_selwadr=10, rf_seldin=10.
  - addi/xori: rf_selwadr=00, rf_seldin=10.
  - lw: rf_selwadr=00, rf_seldin=01.
- HALT: all strobes 0, halted=1. Terminal until reset.
- instr_count increments by 1 on every transition back to FETCH from DECODE, EXEC, MEM or WB. It wraps at 2^32 to 0.
- Outputs are combinational from state, opcode and funct. Unused selects are 00.

## Timing
- Reset asserted: all outputs 0 immediately, including mem_req; state=FETCH; instr_count=0; halted=0.
- First mem_req rises combinationally after reset deasserts. The first edge with mem_ready=1 latches the IR.
- Latency in cycles, with mem_ready=1 on first request:
  - j/jal/jr: 2
  - bne (taken or not): 3
  - R-type/addi/xori: 4
  - sw: 4
  - lw: 5
- Each memory wait cycle adds 1.
- mem_req stays high and address/we stay constant until mem_ready. mem_ready while mem_req=0 is ignored.
- Reset mid-instruction aborts immediately. No partial register or memory write completes after reset asserts.
- Only one write strobe toward a given storage element is active per cycle. pc_wen and rf_wen coincide only for jal.

## Structure
- Package mips_pkg holds opcode/funct constants, state encoding (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7), ALU_* codes, and sel_pc/rf_seldin/rf_selwadr encodings.
- Natural sub-module: alu_decode, a combinational map from opcode and funct to alu_op, sel_b and sgn, plus an illegal flag. It is shared by EXEC and MEM.
- The FSM and instr_count stay in multicycle_ctrl.

## Test plan
- Reset held 3 cycles, then release with mem_ready=1:
  - During reset: mem_req=0, instr_count=0.
  - Cycle 1 after release: FETCH with mem_req=1.
- add (funct 0x20), mem_ready=1: states FETCH, DECODE, EXEC, WB, FETCH. WB shows rf_wen=1, rf_selwadr=10, rf_seldin=10. instr_count becomes 1.
- lw with mem_ready low for 2 MEM cycles: MEM lasts 3 cycles with mem_req=1, mem_sel_adr=1, mem_we=0. WB shows rf_seldin=01. Total 7 cycles.
- bne with alu_zero=0, then alu_zero=1: EXEC pc_wen=1 with sel_pc=01 in the first case; pc_wen=0 in the second. Both return to FETCH.
- jal: DECODE shows pc_wen=1, sel_pc=10, rf_wen=1, rf_selwadr=01, rf_seldin=00; next state FETCH.
- opcode 0x3F: HALT with halted=1 and all strobes 0 indefinitely. Reset returns to FETCH with halted=0.
